ex_muldiv_sequencer: RTL
========================

EX_MULDIV_SEQUENCER -- requirements
Module: ex_muldiv_sequencer

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; state cleared while low.
- start  in  1  EX stage holds a multi-cycle instruction; level, sampled each edge.
- op  in  2  00 MUL (low 32 bits, unsigned); 01 DIVU quotient; 10 REMU remainder; 11 reserved.
- val1  in  32  multiplicand / dividend.
- val2  in  32  multiplier / divisor.
- flush  in  1  branch-taken squash of the EX instruction.
- stall  out  1  freeze PC, IF/ID and ID/EX registers.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- result  out  32  MUL/DIVU/REMU result; held until the next accepted start.
REQ-002 The block SHALL have no parameters; all widths are fixed at 32 data bits and a 5-bit iteration counter.

Function
REQ-003 The block SHALL implement three states: IDLE, CALC, DONE.
REQ-004 IDLE with start=1 and flush=0 SHALL capture op, val1 and val2, clear the accumulator and counter, and go to CALC.
- Exception: op=11 or (op!=00 and val2=0) SHALL go directly to DONE.
REQ-005 CALC SHALL perform exactly 32 iterations, one per cycle, LSB-first for the counter 0..31.
REQ-006 CALC SHALL go to DONE on the edge where counter=31.
REQ-007 MUL SHALL use shift-add on 64-bit product arithmetic; result = product[31:0], unsigned.
REQ-008 DIVU/REMU SHALL use restoring division: shift {rem,quot} left, trial-subtract divisor, and set the quotient bit when the remainder is non-negative.
REQ-009 Divide-by-zero SHALL give DIVU result 32'hFFFFFFFF and REMU result = val1.
REQ-010 op=11 SHALL give result 32'h0000_0000.
REQ-011 Timing for an accepted start at edge N:
- normal op: done=1 during the cycle following edge N+33;
- zero-divisor or op=11: done=1 during the cycle following edge N+1.
REQ-012 stall SHALL be combinational: (IDLE and start and !flush) or CALC.
REQ-013 stall SHALL be 0 in DONE so the pipeline advances exactly once with result valid.
REQ-014 busy SHALL be 1 exactly when the state is CALC.
REQ-015 done SHALL be 1 exactly when the state is DONE.
REQ-016 DONE with start=1 and flush=0 SHALL accept the new operation as in REQ-004 (back-to-back support); otherwise it SHALL go to IDLE.
REQ-017 start SHALL be ignored while in CALC; operands SHALL NOT be re-sampled.
REQ-018 flush=1 in any state SHALL force IDLE at the next edge and suppress done.
- result SHALL remain unchanged.
- flush has priority over start.
REQ-019 result SHALL update only on the transition into DONE.

Reset
REQ-020 While rst=0 the block SHALL be in IDLE, independent of clk.
REQ-021 While rst=0: stall=0 (start ignored), busy=0, done=0, result=0, counter=0, operand and accumulator registers=0.
REQ-022 Reset deasserted mid-CALC SHALL restart from IDLE with no done pulse.
REQ-023 The first start SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-024 MUL: start, op=00, val1=7, val2=6 -> stall for 33 cycles, then done pulse with result=42 and stall=0.
REQ-025 DIVU/REMU:
- op=01, val1=100, val2=7 -> result=14 after 33 cycles;
- op=10, same operands -> result=2.
REQ-026 Divide by zero:
- op=01, val1=5, val2=0 -> done on the next cycle, result=32'hFFFFFFFF, stall high for 1 cycle;
- op=10, same operands -> result=5.
REQ-027 MUL wrap-around: val1=32'hFFFFFFFF, val2=2 -> result=32'hFFFFFFFE. Back-to-back: start held through DONE -> second op begins with no IDLE cycle.
REQ-028 Flush/reset abort:
- flush asserted at counter=10 -> IDLE next cycle, no done pulse, result unchanged;
- rst=0 mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle MUL / DIVU / REMU unit for the EX stage.
// It holds the pipeline while an operation iterates, then pulses done for
// one cycle with the result.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   EX holds a multi-cycle instruction (level, sampled each edge)
//   op      00 MUL (low 32 bits), 01 DIVU quotient, 10 REMU remainder, 11 reserved
//   val1    multiplicand / dividend
//   val2    multiplier / divisor
//   flush   squash of the EX instruction; takes priority over start
//   stall   combinational: freeze PC, IF/ID and ID/EX
//   busy    iteration in progress
//   done    one-cycle pulse, result valid
//   result  last completed result, held until the next completion
module ex_muldiv_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ACC_W  = 64;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Single-step datapath shared by both algorithms
    logic                accept;
    logic                quick;
    logic [DATA_W-1:0]   quick_res;
    logic [ACC_W-1:0]    mul_nxt;
    logic [DATA_W:0]     rem_sh;
    logic                rem_ge;
    logic [DATA_W-1:0]   rem_sub;
    logic [ACC_W-1:0]    div_nxt;

    // Datapath: one shift-add or one restoring-divide step per cycle
    always_comb begin
        // MUL: acc += multiplicand << i when multiplier bit i (b_q LSB) is set
        mul_nxt = acc_q + (b_q[0] ? (ACC_W'(a_q) << cnt_q) : ACC_W'(0));

        // DIV: acc = {rem, quot}; dividend bits feed in MSB-first from a_q
        rem_sh  = {acc_q[ACC_W-1:DATA_W], a_q[DATA_W-1]};
        rem_ge  = (rem_sh >= (DATA_W+1)'(b_q));
        // When rem_ge holds, the true difference is below the divisor, so the
        // low 32 bits of the subtraction are exact.
        rem_sub = rem_sh[DATA_W-1:0] - b_q;
        if (rem_ge) begin
            div_nxt = {rem_sub, acc_q[DATA_W-2:0], 1'b1};
        end else begin
            div_nxt = {rem_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end
    end

    // Operations that complete without iterating: reserved op and divide by zero
    always_comb begin
        accept = start && !flush;
        quick  = (op == OP_RSVD) || ((op != OP_MUL) && (val2 == '0));
        if (op == OP_RSVD) begin
            quick_res = '0;
        end else if (op == OP_DIVU) begin
            quick_res = '1;
        end else begin
            quick_res = val1;
        end
    end

    // Next-state and register-next logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    op_d  = op;
                    a_d   = val1;
                    b_d   = val2;
                    acc_d = '0;
                    cnt_d = '0;
                    if (quick) begin
                        state_d  = ST_DONE;
                        result_d = quick_res;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    if (op_q == OP_MUL) begin
                        acc_d = mul_nxt;
                        b_d   = b_q >> 1;
                    end else begin
                        acc_d = div_nxt;
                        a_d   = a_q << 1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_DONE;
                        if (op_q == OP_MUL) begin
                            result_d = mul_nxt[DATA_W-1:0];
                        end else if (op_q == OP_DIVU) begin
                            result_d = div_nxt[DATA_W-1:0];
                        end else begin
                            result_d = div_nxt[ACC_W-1:DATA_W];
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Stall must already be high in the cycle start is first seen; gated by
    // rst so start is ignored while the block is held in reset.
    assign stall  = rst && (((state_q == ST_IDLE) && start && !flush) ||
                            (state_q == ST_CALC));
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
